// File: rtl/el2_ifu_iccm_bank_ram.sv
// el2_ifu_iccm_bank_ram
//
// Responder side of the ICCM banked-memory interface. It holds one array per
// bank. Each bank returns its read word one cycle after the access, through a
// register. After reset, and again on init_req, a sequencer writes zero (data
// and ECC) to every index. All-zero is a valid codeword, so the controller
// never sees an uninitialised word. A bit-flip fault injector can corrupt the
// output of one (bank, index) location. This lets the controller's ECC
// correction and redundant-row paths be exercised.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   iccm_clken[NB]           per-bank access enable
//   iccm_wren_bank[NB]       per-bank write (1) / read (0), qualified by clken
//   iccm_addr_bank[NB]       per-bank in-bank index (IDX_W bits)
//   iccm_bank_wr_data[NB]    32-bit write data
//   iccm_bank_wr_ecc[NB]     write ECC
//   iccm_bank_dout[NB]       registered read data
//   iccm_bank_ecc[NB]        registered read ECC
//   init_req                 pulse: re-run zero initialisation (READY only)
//   init_done                arrays initialised, accesses honoured
//   inj_arm / inj_clear      pulses: load / disarm the fault registers
//   inj_bank, inj_index      fault target location
//   inj_bit                  bit to flip: 0-31 data, 32-38 ECC, >38 no flip
//   inj_persist              1 = hard fault, 0 = one-shot soft fault
//   inj_active               a fault is armed
//   inj_hit_cnt              faulted reads, saturating at 255
module el2_ifu_iccm_bank_ram #(
    parameter int ICCM_NUM_BANKS     = 4,
    parameter int ICCM_BITS          = 16,
    parameter int ICCM_BANK_INDEX_LO = 4,
    parameter int ICCM_ECC_WIDTH     = 7,
    localparam int NB    = ICCM_NUM_BANKS,
    localparam int IDX_W = ICCM_BITS - ICCM_BANK_INDEX_LO,
    localparam int BW    = $clog2(ICCM_NUM_BANKS),
    localparam int EW    = ICCM_ECC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NB-1:0]             iccm_clken,
    input  logic [NB-1:0]             iccm_wren_bank,
    input  logic [NB-1:0][IDX_W-1:0]  iccm_addr_bank,
    input  logic [NB-1:0][31:0]       iccm_bank_wr_data,
    input  logic [NB-1:0][EW-1:0]     iccm_bank_wr_ecc,
    output logic [NB-1:0][31:0]       iccm_bank_dout,
    output logic [NB-1:0][EW-1:0]     iccm_bank_ecc,
    input  logic                      init_req,
    output logic                      init_done,
    input  logic                      inj_arm,
    input  logic                      inj_clear,
    input  logic [BW-1:0]             inj_bank,
    input  logic [IDX_W-1:0]          inj_index,
    input  logic [5:0]                inj_bit,
    input  logic                      inj_persist,
    output logic                      inj_active,
    output logic [7:0]                inj_hit_cnt
);

    localparam int WW    = 32 + EW;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_cnt_reg, idx_cnt_next;
    logic               init_done_reg, init_done_next;

    logic               inj_active_reg, inj_active_next;
    logic [BW-1:0]      inj_bank_reg;
    logic [IDX_W-1:0]   inj_index_reg;
    logic [5:0]         inj_bit_reg;
    logic               inj_persist_reg;
    logic [7:0]         inj_hit_cnt_reg;
    logic [WW-1:0]      inj_mask;

    logic [NB-1:0]      hit_vec;      // faulted read on this bank
    logic [NB-1:0]      wr_hit_vec;   // write to the fault target on this bank

    logic               is_init, is_ready;

    assign is_init  = (state_reg == ST_INIT);
    assign is_ready = (state_reg == ST_READY);

    // ------------------------------------------------------------------
    // Init sequencer: INIT sweeps idx_cnt over every index, one per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            idx_cnt_reg   <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_cnt_reg   <= idx_cnt_next;
            init_done_reg <= init_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_cnt_next   = idx_cnt_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            ST_INIT: begin
                // init_req is ignored here. A running sweep is never restarted.
                idx_cnt_next = idx_cnt_reg + 1'b1;
                if (idx_cnt_reg == LAST_IDX) begin
                    state_next     = ST_READY;
                    init_done_next = 1'b1;
                    idx_cnt_next   = '0;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_next     = ST_INIT;
                    idx_cnt_next   = '0;
                    init_done_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign init_done = init_done_reg;

    // ------------------------------------------------------------------
    // Fault injector registers
    // ------------------------------------------------------------------
    // Out-of-range bit numbers give an empty mask. The hit is still counted.
    assign inj_mask = (inj_bit_reg < 6'(WW)) ? (WW'(1) << inj_bit_reg) : '0;

    always_comb begin
        inj_active_next = inj_active_reg;
        // Priority: arm beats clear, and clear beats the one-shot
        // self-disarm.
        if (inj_arm) begin
            inj_active_next = 1'b1;
        end else if (inj_clear) begin
            inj_active_next = 1'b0;
        end else if (!inj_persist_reg && ((|hit_vec) || (|wr_hit_vec))) begin
            inj_active_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_active_reg  <= 1'b0;
            inj_bank_reg    <= '0;
            inj_index_reg   <= '0;
            inj_bit_reg     <= '0;
            inj_persist_reg <= 1'b0;
            inj_hit_cnt_reg <= '0;
        end else begin
            inj_active_reg <= inj_active_next;
            if (inj_arm) begin
                inj_bank_reg    <= inj_bank;
                inj_index_reg   <= inj_index;
                inj_bit_reg     <= inj_bit;
                inj_persist_reg <= inj_persist;
            end
            if ((|hit_vec) && (inj_hit_cnt_reg != 8'hFF)) begin
                inj_hit_cnt_reg <= inj_hit_cnt_reg + 8'd1;
            end
        end
    end

    assign inj_active  = inj_active_reg;
    assign inj_hit_cnt = inj_hit_cnt_reg;

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
        logic [WW-1:0]    mem_reg [DEPTH];
        logic [WW-1:0]    dout_reg;
        logic             mem_we;
        logic [IDX_W-1:0] mem_addr;
        logic [WW-1:0]    mem_wdata;
        logic             rd_en;
        logic             tgt;

        // During INIT the sequencer owns the write port of every bank.
        assign mem_we    = is_init | (is_ready & iccm_clken[gi] & iccm_wren_bank[gi]);
        assign mem_addr  = is_init ? idx_cnt_reg : iccm_addr_bank[gi];
        assign mem_wdata = is_init ? '0 : {iccm_bank_wr_ecc[gi], iccm_bank_wr_data[gi]};

        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem_reg[mem_addr] <= mem_wdata;
            end
        end

        assign rd_en = is_ready & iccm_clken[gi] & ~iccm_wren_bank[gi];
        assign tgt   = inj_active_reg & (inj_bank_reg == BW'(gi))
                     & (iccm_addr_bank[gi] == inj_index_reg);
        assign hit_vec[gi]    = rd_en & tgt;
        assign wr_hit_vec[gi] = is_ready & iccm_clken[gi] & iccm_wren_bank[gi] & tgt;

        // The flip is applied only on the way out. The stored word stays
        // intact.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_reg <= '0;
            end else if (is_init) begin
                dout_reg <= '0;
            end else if (rd_en) begin
                dout_reg <= mem_reg[iccm_addr_bank[gi]] ^ (hit_vec[gi] ? inj_mask : '0);
            end
        end

        assign iccm_bank_dout[gi] = dout_reg[31:0];
        assign iccm_bank_ecc[gi]  = dout_reg[WW-1:32];
    end

endmodule

// File: tb/tb_el2_ifu_iccm_bank_ram.sv
module tb_el2_ifu_iccm_bank_ram;

    localparam int NB    = 4;
    localparam int IDX_W = 12;
    localparam int DEPTH = 4096;
    localparam int EW    = 7;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NB-1:0]            clken;
    logic [NB-1:0]            wren;
    logic [NB-1:0][IDX_W-1:0] addr;
    logic [NB-1:0][31:0]      wdata;
    logic [NB-1:0][EW-1:0]    wecc;
    logic [NB-1:0][31:0]      dout;
    logic [NB-1:0][EW-1:0]    ecc;
    logic                     init_req;
    logic                     init_done;
    logic                     inj_arm;
    logic                     inj_clear;
    logic [1:0]               inj_bank;
    logic [IDX_W-1:0]         inj_index;
    logic [5:0]               inj_bit;
    logic                     inj_persist;
    logic                     inj_active;
    logic [7:0]               inj_hit_cnt;

    int checks = 0;
    int errors = 0;
    int n;

    el2_ifu_iccm_bank_ram dut (
        .clk               (clk),
        .rst               (rst),
        .iccm_clken        (clken),
        .iccm_wren_bank    (wren),
        .iccm_addr_bank    (addr),
        .iccm_bank_wr_data (wdata),
        .iccm_bank_wr_ecc  (wecc),
        .iccm_bank_dout    (dout),
        .iccm_bank_ecc     (ecc),
        .init_req          (init_req),
        .init_done         (init_done),
        .inj_arm           (inj_arm),
        .inj_clear         (inj_clear),
        .inj_bank          (inj_bank),
        .inj_index         (inj_index),
        .inj_bit           (inj_bit),
        .inj_persist       (inj_persist),
        .inj_active        (inj_active),
        .inj_hit_cnt       (inj_hit_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Count edges until init_done rises, bounded.
    task automatic wait_init(inout int cnt);
        while (!init_done && cnt < DEPTH + 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic arm(input int b, input int idx, input int bitn, input logic p);
        inj_arm = 1'b1; inj_bank = 2'(b); inj_index = IDX_W'(idx);
        inj_bit = 6'(bitn); inj_persist = p;
        tick();
        inj_arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clken = '0; wren = '0; addr = '0; wdata = '0; wecc = '0;
        init_req = 1'b0; inj_arm = 1'b0; inj_clear = 1'b0;
        inj_bank = '0; inj_index = '0; inj_bit = '0; inj_persist = 1'b0;
        tick(); tick();
        check("rst_dout",      64'(dout),        64'd0);
        check("rst_ecc",       64'(ecc),         64'd0);
        check("rst_init_done", 64'(init_done),   64'd0);
        check("rst_inj_active",64'(inj_active),  64'd0);
        check("rst_hit_cnt",   64'(inj_hit_cnt), 64'd0);

        // Initial sweep takes exactly DEPTH edges after reset release.
        rst = 1'b0;
        n = 0;
        wait_init(n);
        check("init_len", 64'(n), 64'(DEPTH));

        // Read of a freshly initialised location.
        clken = 4'b0100; addr[2] = 12'h005;
        tick();
        clken = '0;
        check("init_rd_data", 64'(dout[2]), 64'd0);
        check("init_rd_ecc",  64'(ecc[2]),  64'd0);

        // Write then read, bank 1 index 0x3A.
        clken = 4'b0010; wren = 4'b0010; addr[1] = 12'h03A;
        wdata[1] = 32'hDEADBEEF; wecc[1] = 7'h15;
        tick();
        check("wr_no_through", 64'(dout[1]), 64'd0);
        wren = '0;
        tick();
        clken = '0;
        check("rd_data", 64'(dout[1]), 64'hDEADBEEF);
        check("rd_ecc",  64'(ecc[1]),  64'h15);

        // One-shot fault on data bit 4.
        arm(1, 12'h03A, 4, 1'b0);
        check("arm_active", 64'(inj_active), 64'd1);
        clken = 4'b0010;
        tick();
        check("oneshot_rd1",     64'(dout[1]),     64'hDEADBEFF);
        check("oneshot_inactive",64'(inj_active),  64'd0);
        check("oneshot_cnt",     64'(inj_hit_cnt), 64'd1);
        tick();
        clken = '0;
        check("oneshot_rd2",     64'(dout[1]),     64'hDEADBEEF);
        check("oneshot_cnt2",    64'(inj_hit_cnt), 64'd1);

        // Persistent fault on ECC bit 3, survives a write to the target.
        arm(0, 7, 35, 1'b1);
        clken = 4'b0001; wren = 4'b0001; addr[0] = 12'h007;
        wdata[0] = 32'h12345678; wecc[0] = 7'h00;
        tick();
        check("persist_after_wr", 64'(inj_active), 64'd1);
        // Bank 0 and bank 1 read together; only bank 0 is faulted.
        wren = '0; clken = 4'b0011;
        tick();
        clken = '0;
        check("persist_ecc",  64'(ecc[0]),      64'h08);
        check("persist_data", 64'(dout[0]),     64'h12345678);
        check("other_data",   64'(dout[1]),     64'hDEADBEEF);
        check("other_ecc",    64'(ecc[1]),      64'h15);
        check("persist_cnt",  64'(inj_hit_cnt), 64'd2);
        inj_clear = 1'b1;
        tick();
        inj_clear = 1'b0;
        check("clear_inactive", 64'(inj_active), 64'd0);
        clken = 4'b0001;
        tick();
        clken = '0;
        check("clear_ecc", 64'(ecc[0]), 64'h00);
        check("clear_cnt", 64'(inj_hit_cnt), 64'd2);

        // Out-of-range bit: no flip, hit still counted.
        arm(0, 7, 50, 1'b1);
        clken = 4'b0001;
        tick();
        clken = '0;
        check("bit50_data", 64'(dout[0]),     64'h12345678);
        check("bit50_ecc",  64'(ecc[0]),      64'h00);
        check("bit50_cnt",  64'(inj_hit_cnt), 64'd3);

        // Saturation: 300 faulted reads on bank 3 index 0, bit 0.
        arm(3, 0, 0, 1'b1);
        clken = 4'b1000; addr[3] = 12'h000;
        tick();
        check("sat_first_data", 64'(dout[3]), 64'h1);
        for (int i = 1; i < 300; i++) tick();
        clken = '0;
        check("sat_cnt", 64'(inj_hit_cnt), 64'd255);
        inj_clear = 1'b1;
        tick();
        inj_clear = 1'b0;

        // Re-initialise from READY.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        check("reinit_done_low", 64'(init_done), 64'd0);
        n = 0;
        clken = 4'b0010; addr[1] = 12'h03A;
        tick(); n++;
        clken = '0;
        check("init_rd_held0", 64'(dout[1]), 64'd0);
        arm(2, 9, 1, 1'b0); n++;
        check("arm_in_init", 64'(inj_active), 64'd1);
        wait_init(n);
        check("reinit_len", 64'(n), 64'(DEPTH));
        clken = 4'b0011; addr[0] = 12'h007; addr[1] = 12'h03A;
        tick();
        check("reinit_b0", 64'(dout[0]), 64'd0);
        check("reinit_b1", 64'(dout[1]), 64'd0);
        check("reinit_b1e",64'(ecc[1]),  64'd0);
        clken = 4'b0100; addr[2] = 12'h009;
        tick();
        clken = '0;
        check("init_armed_hit", 64'(dout[2]),     64'h2);
        check("init_armed_off", 64'(inj_active),  64'd0);
        check("sat_hold",       64'(inj_hit_cnt), 64'd255);

        // Reset in the middle of a sweep.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt",  64'(inj_hit_cnt), 64'd0);
        check("async_rst_done", 64'(init_done),   64'd0);
        check("async_rst_dout", 64'(dout),        64'd0);
        tick();
        rst = 1'b0;
        n = 0;
        // init_req during INIT must not extend the sweep.
        for (int i = 0; i < 2000; i++) begin tick(); n++; end
        init_req = 1'b1;
        tick(); n++;
        init_req = 1'b0;
        wait_init(n);
        check("rst_restart_len", 64'(n), 64'(DEPTH));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
